pio_input_debounce: RTL
=======================

# pio_input_debounce

Synchronises and debounces a bank of raw board inputs (push-buttons, slide switches) and drives the cleaned levels onto the `in_port` of the HPS-facing edge-capture PIO. Raw pins are asynchronous and bouncy. Without this stage the PIO's edge-capture register latches every bounce as an event. Channels are independent and share one timebase prescaler.

## Interface
Parameters:
- `WIDTH`, 12: number of input channels; matches the PIO `in_port` width.
- `TICK_DIV`, 50000: clock cycles per debounce tick (1 ms at 50 MHz). Must be at least 1.
- `STABLE_TICKS`, 20: consecutive ticks a new level must persist before it is accepted. Must be at least 1.
- `RESET_VALUE`, {WIDTH{1'b0}}: value loaded into the sync flops and `clean_out` on reset.

Ports:
- `clk`  in  1  the single clock; all logic is in this domain.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `raw_in`  in  WIDTH  raw pin levels; asynchronous to `clk`.
- `clean_out`  out  WIDTH  debounced levels; connects to PIO `in_port`. Registered.
- `change_pulse`  out  WIDTH  one-cycle strobe per channel on each `clean_out` transition. Present only with `PIO_DEBOUNCE_CHANGE_PULSE_EN`.

## Operation
- **Synchroniser:** each channel has two flops, `sync1 <= raw_in` and `sync2 <= sync1`. Both reset to `RESET_VALUE`. Only `sync2` is used downstream.
- **Prescaler:** counter `pre` runs 0..TICK_DIV-1 and resets to 0. The `tick` signal is high for the single cycle in which `pre == TICK_DIV-1`, and `pre` wraps to 0 on that edge. With TICK_DIV=1, `tick` is high every cycle.
- **Per-channel states:** each channel is in one of two states, STABLE (`sync2 == clean_out`) or PENDING (they differ). Each channel has its own counter `cnt`, width `$clog2(STABLE_TICKS)`, minimum 1 bit, reset 0.
- **STABLE:** `cnt <= 0` every cycle, regardless of `tick`.
- **PENDING, no tick:** `cnt` holds.
- **PENDING, tick, `cnt != STABLE_TICKS-1`:** `cnt <= cnt+1`.
- **PENDING, tick, `cnt == STABLE_TICKS-1`:** `clean_out <= sync2` and `cnt <= 0`, so the channel returns to STABLE.
- **Glitch rule:** a single cycle of `sync2` matching `clean_out` clears `cnt`. A bounce therefore restarts the full qualification window.
- **Channel independence:** channels never interact. Any number may transition on the same edge.
- **Reset:** reset mid-qualification discards all progress. `pre`, `cnt`, `sync1`, `sync2` and `clean_out` return to reset values asynchronously.
- **Reset values:** `clean_out` = `RESET_VALUE`. `change_pulse` = 0.

## Timing
- Edge 1 is the first rising edge that samples a new `raw_in` level into `sync1`. `sync2` holds the new level after edge 2.
- **Latency bounds:** `clean_out` updates between edge 2+(STABLE_TICKS-1)·TICK_DIV+1 and edge 2+STABLE_TICKS·TICK_DIV inclusive. The exact edge depends on prescaler phase.
- **Rejection threshold:** a pulse on `raw_in` shorter than (STABLE_TICKS-1)·TICK_DIV+1 cycles is always rejected.
- **Throughput:** there is no back-pressure. A new level on a channel is accepted at most once per qualification window.
- **`change_pulse` timing:** `change_pulse[i]` is registered. It is high exactly during the first cycle in which `clean_out[i]` shows its new value, and low otherwise.

## Configuration
- **With `PIO_DEBOUNCE_CHANGE_PULSE_EN`:** the `change_pulse` port is present, driven as `clean_out` XOR its one-cycle-delayed copy, registered so it is aligned with the new `clean_out` value.
- **Without the macro:** the port and its delay register are absent. `clean_out` behaviour is identical in both builds.

## Structure
- **Shared package `pio_debounce_pkg`:**
  - default constants `PIO_DEBOUNCE_TICK_DIV` (50000), `PIO_DEBOUNCE_STABLE_TICKS` (20) and `PIO_DEBOUNCE_WIDTH` (12);
  - function `cnt_width(n)` returning max(1, `$clog2(n)`).
- **Sub-module `pio_debounce_channel`:** one channel's synchroniser, `cnt` and output flop. It takes `tick` as an input and is instantiated WIDTH times via generate.
- **Top level:** the prescaler and the optional `change_pulse` logic live in the top level.

## Test plan
All scenarios use WIDTH=12, TICK_DIV=4, STABLE_TICKS=3, RESET_VALUE=12'h000 unless stated.
- **Reset:** hold `reset_n`=0 with `raw_in`=12'hFFF -> `clean_out`=12'h000 and `change_pulse`=0. Release reset with `raw_in`=12'h000 -> `clean_out` stays 12'h000 indefinitely.
- **Clean step:** `raw_in[0]` 0→1 and held -> `clean_out[0]` rises between edges 11 and 14. With the macro, `change_pulse[0]` is high for exactly 1 cycle, aligned with the rise; all other bits stay 0.
- **Bounce:** toggle `raw_in[3]` with 1-cycle highs every 3 cycles for 40 cycles, then hold at 0 -> `clean_out[3]` never changes and `change_pulse[3]` is never asserted.
- **Simultaneous channels:** `raw_in` 12'h000→12'hA5A in one cycle -> all six bits update on the same edge, and the other bits stay 0. Then go back to 12'h000 -> the same bits fall together.
- **Reset mid-qualification:** step `raw_in[5]` to 1, pulse `reset_n` low at edge 8 -> `clean_out[5]` stays 0 through reset. After release, `clean_out[5]` rises within 14 edges of the first sampling edge, counted fresh.
- **Edge case STABLE_TICKS=1, TICK_DIV=1:** step `raw_in[11]` to 1 -> `clean_out[11]` rises at edge 3 exactly.

Source files
------------

// File: rtl/pio_debounce_pkg.sv
// Shared constants and helpers for the PIO input debouncer.
package pio_debounce_pkg;

  localparam int PIO_DEBOUNCE_TICK_DIV     = 50000;
  localparam int PIO_DEBOUNCE_STABLE_TICKS = 20;
  localparam int PIO_DEBOUNCE_WIDTH        = 12;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pio_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, qualification counter, output flop.
// Exposes the accept strobe only when PIO_DEBOUNCE_CHANGE_PULSE_EN is defined.
module pio_debounce_channel
  import pio_debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = PIO_DEBOUNCE_STABLE_TICKS,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
`ifdef PIO_DEBOUNCE_CHANGE_PULSE_EN
  output logic accept,
`endif
  output logic clean
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          pending, take;

  assign pending = (sync2 != clean);
  assign take    = pending && tick && (cnt == CNT_LAST);

`ifdef PIO_DEBOUNCE_CHANGE_PULSE_EN
  assign accept = take;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
      clean <= RESET_VALUE;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any cycle back at the accepted level restarts the whole window.
      if (!pending) begin
        cnt <= '0;
      end else if (tick) begin
        if (take) begin
          clean <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pio_input_debounce.sv
// Bank of debounced board inputs feeding the HPS edge-capture PIO in_port.
// Define PIO_DEBOUNCE_CHANGE_PULSE_EN to add the per-channel change_pulse output.
module pio_input_debounce
  import pio_debounce_pkg::*;
#(
  parameter int               WIDTH        = PIO_DEBOUNCE_WIDTH,
  parameter int               TICK_DIV     = PIO_DEBOUNCE_TICK_DIV,
  parameter int               STABLE_TICKS = PIO_DEBOUNCE_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
`ifdef PIO_DEBOUNCE_CHANGE_PULSE_EN
  output logic [WIDTH-1:0] change_pulse,
`endif
  output logic [WIDTH-1:0] clean_out
);

  localparam int            PW       = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;

  // Shared timebase; with TICK_DIV=1 pre sits at 0 and tick is always high.
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

`ifdef PIO_DEBOUNCE_CHANGE_PULSE_EN
  logic [WIDTH-1:0] accept;

  // Registered from the same condition that loads clean_out, so both land on one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) change_pulse <= '0;
    else          change_pulse <= accept;
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_VALUE  (RESET_VALUE[i])
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .raw     (raw_in[i]),
`ifdef PIO_DEBOUNCE_CHANGE_PULSE_EN
      .accept  (accept[i]),
`endif
      .clean   (clean_out[i])
    );
  end

endmodule
